rap_resolver: RTL and testbench
===============================

# rap_resolver

Execute-stage companion to the return-address predictor. Records every return-target prediction the predictor issues at Fetch, matches it against the `ret` (`jalr x0, 0(ra)`) that reaches Execute, and compares the predicted target with the resolved target. It reports mispredictions with the redirect PC, signals executed returns so the predictor can pop its TOS-repair stack, and keeps hit/miss statistics.

## Interface
- `PQ_DEPTH`, 4: in-flight prediction queue entries; power of two, ≥ 4.
- `XLEN`, 32: address width.
- `clk_i`  in  1  single clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `stall_i`  in  1  pipeline stall; blocks push, pop and counter updates.
- `stall_data_hazard_i`  in  1  data-hazard stall; blocks push only.
- `flush_i`  in  1  pipeline flush; squashes Fetch/Decode contents.
- `rap_hit_i`  in  1  predictor hit at Fetch, from the predictor's hit output.
- `fetch_pc_i`  in  XLEN  PC of the predicted instruction at Fetch.
- `rap_pc_i`  in  XLEN  predicted return target at Fetch.
- `exe_is_ret_i`  in  1  instruction at Execute is a `ret`.
- `exe_pc_i`  in  XLEN  PC of the instruction at Execute.
- `exe_target_i`  in  XLEN  resolved `jalr` target at Execute.
- `rap_misprediction_o`  out  1  registered pulse: a predicted `ret` resolved to a different target.
- `redirect_pc_o`  out  XLEN  correct target; valid with `rap_misprediction_o`.
- `exe_ret_executed_o`  out  1  registered pulse: a `ret` was resolved at Execute.
- `ret_cnt_o`  out  32  resolved `ret` count.
- `ret_miss_cnt_o`  out  32  mispredicted `ret` count.
- `pq_overflow_o`  out  1  sticky: a push was dropped because the queue was full.

## Operation
- **Queue.** A circular FIFO of `PQ_DEPTH` entries, each holding `{fetch_pc, pred_target}`. Read pointer `rp` and write pointer `wp` are `log2(PQ_DEPTH)` bits wide and wrap modulo `PQ_DEPTH`. A separate `count` (0..`PQ_DEPTH`) distinguishes full from empty.
- **Push.**
  - Fires when `rap_hit_i & !stall_i & !stall_data_hazard_i & !flush_i`. This matches the predictor's pop condition, less squashed fetches.
  - Writes `{fetch_pc_i, rap_pc_i}` at `wp`, then `wp++`.
  - If the queue is full and no pop occurs in the same cycle, the push is dropped and `pq_overflow_o` is set. It stays set until reset.
- **Resolve.** Fires when `exe_is_ret_i & !stall_i`.
  - Next cycle, `exe_ret_executed_o` = 1 and `ret_cnt_o` increments.
  - **Predicted case:** `count != 0` and `head.fetch_pc == exe_pc_i`.
    - Pop the head (`rp++`).
    - If `head.pred_target != exe_target_i`: next cycle `rap_misprediction_o` = 1, `redirect_pc_o` = `exe_target_i`, and `ret_miss_cnt_o` increments.
  - **Unpredicted case:** queue empty or head PC differs.
    - No pop and no misprediction. The normal branch path handles this `ret`.
- **Flush.** `flush_i & !stall_i` first applies that cycle's resolve, including any pop. It then empties the queue: `rp` ← `wp`, `count` ← 0.
- **Push and pop in the same cycle.** Both are applied and `count` is unchanged. This holds when full (the push is accepted) and when empty (impossible, since a pop needs a valid head).
- **Counters.** 32-bit, wrap from 0xFFFF_FFFF to 0. They are not cleared by flush.

## Timing
- **Reset values.** All outputs are 0; `rp`, `wp` and `count` are 0; queue contents are don't-care.
- **Latency.** Resolve at edge N gives the output pulses in cycle N+1. Each pulse lasts exactly one cycle, even if `stall_i` is high in N+1.
- **`redirect_pc_o`.** Holds its last value when not mispredicting.
- **Stall.** While `stall_i` is high: queue, pointers and counters are frozen, and pending pulses deassert.
- **Reset during activity.** `rst_i` has priority over every push, pop and flush. The queue is emptied and no pulse is emitted the following cycle.
- **Throughput.** One push and one resolve per cycle at most.

## Test plan
- **Correct prediction.** Push `{pc=0x100, tgt=0x204}`, then resolve `ret` with `exe_pc=0x100`, `exe_target=0x204` → `exe_ret_executed_o`=1, `rap_misprediction_o`=0, `ret_cnt_o`=1, queue empty.
- **Wrong target.** Push `{0x100, 0x204}`, then resolve with target `0x308` → `rap_misprediction_o`=1, `redirect_pc_o`=0x308, `ret_miss_cnt_o`=1.
- **Unpredicted return.** Empty queue, resolve `ret` at 0x400 → `exe_ret_executed_o`=1, no misprediction, `count` stays 0.
- **Flush with pending pushes.** Push three entries, then assert `flush_i` in the same cycle as resolving the head (target matches) → head popped without misprediction, `count`=0 afterwards, and a same-cycle `rap_hit_i` is not queued.
- **Full queue.**
  - Five pushes with no pop → `pq_overflow_o`=1 and `count`=4.
  - Then push and resolve in the same cycle → `count`=4 and the new entry sits at the tail.
- **Stall and reset.**
  - `stall_i` held 3 cycles during `rap_hit_i` and `exe_is_ret_i` → no state change.
  - `rst_i` mid-stream → all outputs 0 next cycle and the counters cleared.

Source files
------------

// File: rtl/rap_resolver.sv
// rap_resolver: matches Fetch-stage return-address predictions against rets resolved at Execute,
// flags wrong targets with a redirect PC and keeps hit/miss statistics.
module rap_resolver #(
  parameter int PQ_DEPTH = 4,
  parameter int XLEN     = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            stall_data_hazard_i,
  input  logic            flush_i,
  input  logic            rap_hit_i,
  input  logic [XLEN-1:0] fetch_pc_i,
  input  logic [XLEN-1:0] rap_pc_i,
  input  logic            exe_is_ret_i,
  input  logic [XLEN-1:0] exe_pc_i,
  input  logic [XLEN-1:0] exe_target_i,
  output logic            rap_misprediction_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            exe_ret_executed_o,
  output logic [31:0]     ret_cnt_o,
  output logic [31:0]     ret_miss_cnt_o,
  output logic            pq_overflow_o
);
  localparam int AW = $clog2(PQ_DEPTH);
  logic [XLEN-1:0] pc_mem_q  [PQ_DEPTH];
  logic [XLEN-1:0] tgt_mem_q [PQ_DEPTH];
  logic [AW-1:0]   rp_q, rp_d, wp_q, wp_d;
  logic [AW:0]     count_q, count_d;
  logic            mis_q, mis_d, exec_q, exec_d, ovf_q, ovf_d;
  logic [XLEN-1:0] redirect_q, redirect_d;
  logic [31:0]     ret_cnt_q, ret_cnt_d, miss_cnt_q, miss_cnt_d;
  logic            push_req, push, resolve, pop, full, flush_eff;
  always_comb begin
    push_req   = rap_hit_i & ~stall_i & ~stall_data_hazard_i & ~flush_i;
    resolve    = exe_is_ret_i & ~stall_i;
    flush_eff  = flush_i & ~stall_i;
    full       = count_q == (AW+1)'(PQ_DEPTH);
    pop        = resolve & (count_q != '0) & (pc_mem_q[rp_q] == exe_pc_i);
    // a full queue still accepts a push when the head retires in the same cycle
    push       = push_req & (~full | pop);
    mis_d      = pop & (tgt_mem_q[rp_q] != exe_target_i);
    exec_d     = resolve;
    redirect_d = mis_d ? exe_target_i : redirect_q;
    ret_cnt_d  = ret_cnt_q + 32'(resolve);
    miss_cnt_d = miss_cnt_q + 32'(mis_d);
    ovf_d      = ovf_q | (push_req & full & ~pop);
    wp_d       = wp_q + AW'(push);
    rp_d       = flush_eff ? wp_d : rp_q + AW'(pop);
    count_d    = flush_eff ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rp_q       <= '0;
      wp_q       <= '0;
      count_q    <= '0;
      mis_q      <= 1'b0;
      exec_q     <= 1'b0;
      ovf_q      <= 1'b0;
      redirect_q <= '0;
      ret_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      rp_q       <= rp_d;
      wp_q       <= wp_d;
      count_q    <= count_d;
      mis_q      <= mis_d;
      exec_q     <= exec_d;
      ovf_q      <= ovf_d;
      redirect_q <= redirect_d;
      ret_cnt_q  <= ret_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      pc_mem_q[wp_q]  <= fetch_pc_i;
      tgt_mem_q[wp_q] <= rap_pc_i;
    end
  end
  assign rap_misprediction_o = mis_q;
  assign redirect_pc_o       = redirect_q;
  assign exe_ret_executed_o  = exec_q;
  assign ret_cnt_o           = ret_cnt_q;
  assign ret_miss_cnt_o      = miss_cnt_q;
  assign pq_overflow_o       = ovf_q;
endmodule

// File: tb/tb_rap_resolver.sv
// tb_rap_resolver: directed cycle-by-cycle vectors for rap_resolver with hand-computed expectations.
module tb_rap_resolver;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0, stall_data_hazard_i = 1'b0, flush_i = 1'b0, rap_hit_i = 1'b0;
  logic [31:0] fetch_pc_i = '0, rap_pc_i = '0, exe_pc_i = '0, exe_target_i = '0;
  logic        exe_is_ret_i = 1'b0;
  logic        rap_misprediction_o, exe_ret_executed_o, pq_overflow_o;
  logic [31:0] redirect_pc_o, ret_cnt_o, ret_miss_cnt_o;
  int          n_cmp = 0, n_fail = 0;
  typedef struct {
    logic        rst, stall, sdh, flush, hit;
    logic [31:0] fpc, rpc;
    logic        ret;
    logic [31:0] epc, etgt;
    logic        mis;
    logic [31:0] redir;
    logic        exec;
    logic [31:0] rc, mc;
    logic        ovf;
    logic [2:0]  cnt;
  } vec_t;
  vec_t tbl[$];
  rap_resolver #(.PQ_DEPTH(4), .XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .stall_data_hazard_i(stall_data_hazard_i),
    .flush_i(flush_i), .rap_hit_i(rap_hit_i), .fetch_pc_i(fetch_pc_i), .rap_pc_i(rap_pc_i),
    .exe_is_ret_i(exe_is_ret_i), .exe_pc_i(exe_pc_i), .exe_target_i(exe_target_i),
    .rap_misprediction_o(rap_misprediction_o), .redirect_pc_o(redirect_pc_o),
    .exe_ret_executed_o(exe_ret_executed_o), .ret_cnt_o(ret_cnt_o),
    .ret_miss_cnt_o(ret_miss_cnt_o), .pq_overflow_o(pq_overflow_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic apply(input vec_t v, input string nm);
    logic [2:0] cnt;
    @(negedge clk_i);
    rst_i = v.rst; stall_i = v.stall; stall_data_hazard_i = v.sdh; flush_i = v.flush;
    rap_hit_i = v.hit; fetch_pc_i = v.fpc; rap_pc_i = v.rpc;
    exe_is_ret_i = v.ret; exe_pc_i = v.epc; exe_target_i = v.etgt;
    @(posedge clk_i);
    #1;
    cnt = dut.count_q;
    n_cmp++;
    if ({rap_misprediction_o, redirect_pc_o, exe_ret_executed_o, ret_cnt_o, ret_miss_cnt_o, pq_overflow_o, cnt} !==
        {v.mis, v.redir, v.exec, v.rc, v.mc, v.ovf, v.cnt}) begin
      n_fail++;
      $display("FAIL %s: got mis=%0b redir=%h exec=%0b ret=%0d miss=%0d ovf=%0b cnt=%0d, want mis=%0b redir=%h exec=%0b ret=%0d miss=%0d ovf=%0b cnt=%0d",
               nm, rap_misprediction_o, redirect_pc_o, exe_ret_executed_o, ret_cnt_o, ret_miss_cnt_o, pq_overflow_o, cnt,
               v.mis, v.redir, v.exec, v.rc, v.mc, v.ovf, v.cnt);
    end
  endtask
  initial begin
    vec_t h;
    //              rst st sdh fl hit fpc    rpc    ret epc    etgt    mis redir  ex rc  mc ovf cnt
    tbl.push_back('{1, 0, 0, 0, 0, 'h0,   'h0,   0, 'h0,   'h0,    0, 'h0,   0, 0,  0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 'h100, 'h204, 0, 'h0,   'h0,    0, 'h0,   0, 0,  0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 'h0,   'h0,   1, 'h100, 'h204,  0, 'h0,   1, 1,  0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 'h100, 'h204, 0, 'h0,   'h0,    0, 'h0,   0, 1,  0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 'h0,   'h0,   1, 'h100, 'h308,  1, 'h308, 1, 2,  1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 'h0,   'h0,   0, 'h0,   'h0,    0, 'h308, 0, 2,  1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 'h0,   'h0,   1, 'h400, 'h555,  0, 'h308, 1, 3,  1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 'h110, 'ha0,  0, 'h0,   'h0,    0, 'h308, 0, 3,  1, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 1, 'h120, 'hb0,  0, 'h0,   'h0,    0, 'h308, 0, 3,  1, 0, 2});
    tbl.push_back('{0, 0, 0, 0, 1, 'h130, 'hc0,  0, 'h0,   'h0,    0, 'h308, 0, 3,  1, 0, 3});
    tbl.push_back('{0, 0, 0, 1, 1, 'h140, 'hd0,  1, 'h110, 'ha0,   0, 'h308, 1, 4,  1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 'h0,   'h0,   1, 'h120, 'h999,  0, 'h308, 1, 5,  1, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 'h200, 'h20,  0, 'h0,   'h0,    0, 'h308, 0, 5,  1, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 1, 'h210, 'h21,  0, 'h0,   'h0,    0, 'h308, 0, 5,  1, 0, 2});
    tbl.push_back('{0, 0, 0, 0, 1, 'h220, 'h22,  0, 'h0,   'h0,    0, 'h308, 0, 5,  1, 0, 3});
    tbl.push_back('{0, 0, 0, 0, 1, 'h230, 'h23,  0, 'h0,   'h0,    0, 'h308, 0, 5,  1, 0, 4});
    tbl.push_back('{0, 0, 0, 0, 1, 'h240, 'h24,  0, 'h0,   'h0,    0, 'h308, 0, 5,  1, 1, 4});
    tbl.push_back('{0, 0, 0, 0, 1, 'h250, 'h25,  1, 'h200, 'h20,   0, 'h308, 1, 6,  1, 1, 4});
    tbl.push_back('{0, 0, 0, 0, 0, 'h0,   'h0,   1, 'h210, 'h99,   1, 'h99,  1, 7,  2, 1, 3});
    tbl.push_back('{0, 0, 0, 0, 0, 'h0,   'h0,   1, 'h220, 'h22,   0, 'h99,  1, 8,  2, 1, 2});
    tbl.push_back('{0, 0, 0, 0, 0, 'h0,   'h0,   1, 'h230, 'h23,   0, 'h99,  1, 9,  2, 1, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 'h0,   'h0,   1, 'h250, 'h77,   1, 'h77,  1, 10, 3, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 'h300, 'h30,  0, 'h0,   'h0,    0, 'h77,  0, 10, 3, 1, 1});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{0, 1, 0, 0, 1, 'h310, 'h31, 1, 'h300, 'h99,  0, 'h77,  0, 10, 3, 1, 1});
    tbl.push_back('{0, 0, 1, 0, 1, 'h320, 'h32,  1, 'h300, 'h30,   0, 'h77,  1, 11, 3, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 'h0,   'h0,   1, 'h500, 'h50,   0, 'h77,  1, 12, 3, 1, 0});
    tbl.push_back('{0, 1, 0, 0, 0, 'h0,   'h0,   0, 'h0,   'h0,    0, 'h77,  0, 12, 3, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 'h600, 'h60,  0, 'h0,   'h0,    0, 'h77,  0, 12, 3, 1, 1});
    tbl.push_back('{1, 0, 0, 0, 1, 'h610, 'h61,  1, 'h600, 'h66,   0, 'h0,   0, 0,  0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 'h0,   'h0,   1, 'h600, 'h60,   0, 'h0,   1, 1,  0, 0, 0});
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
    // misprediction pulse stays one cycle even when a stall follows
    h = '{0, 0, 0, 0, 1, 'h700, 'h70, 0, 'h0, 'h0, 0, 'h0, 0, 1, 0, 0, 1};
    apply(h, "seq_push");
    h = '{0, 0, 0, 0, 0, 'h0, 'h0, 1, 'h700, 'h71, 1, 'h71, 1, 2, 1, 0, 0};
    apply(h, "seq_miss");
    h = '{0, 1, 0, 0, 0, 'h0, 'h0, 1, 'h700, 'h72, 0, 'h71, 0, 2, 1, 0, 0};
    apply(h, "seq_stall_after_miss");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
